l1a_multi_checker: RTL and testbench

L1A_MULTI_CHECKER -- requirements
Module: l1a_multi_checker

---
 rtl/l1a_chk_pkg.sv | 30 +++
 rtl/l1a_multi_checker_save_bank.sv | 38 +++
 rtl/l1a_multi_checker.sv | 200 ++++++++++++++++++++
 tb/tb_l1a_multi_checker.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/l1a_chk_pkg.sv
// Shared types and width helpers for the L1A multi-channel checker.
package l1a_chk_pkg;

    typedef enum logic [3:0] {
        S_IDLE, S_HOLD, S_SCAN, S_WAIT, S_POP,
        S_CHECK, S_PROC, S_FLUSH, S_NOEND, S_TAIL
    } state_t;

    function automatic int l1a_width(input int npop, input int dw);
        return npop * dw;
    endfunction

    function automatic int sel_width(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

    function automatic int tmo_width(input int tmo);
        return $clog2(tmo + 1);
    endfunction

    // Index of the lowest set bit; channels are scanned low to high.
    function automatic logic [3:0] lowest_set(input logic [15:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int i = 15; i >= 0; i--)
            if (v[i]) idx = 4'(i);
        return idx;
    endfunction

endpackage

// File: rtl/l1a_multi_checker_save_bank.sv
// Per-channel storage for headers that arrived ahead of the expected L1A.
module l1a_save_bank #(
    parameter int NCH  = 7,
    parameter int L1AW = 24,
    parameter int SW   = 3
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            wr_en,
    input  logic [SW-1:0]   wr_idx,
    input  logic [L1AW-1:0] wr_data,
    input  logic            clr_en,
    input  logic [SW-1:0]   clr_idx,
    input  logic [SW-1:0]   rd_idx,
    output logic [L1AW-1:0] rd_data,
    output logic            rd_vld
);

    logic [NCH-1:0][L1AW-1:0] val;
    logic [NCH-1:0]           vld;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            val <= '0;
            vld <= '0;
        end else begin
            if (clr_en) vld[clr_idx] <= 1'b0;
            if (wr_en) begin
                val[wr_idx] <= wr_data;
                vld[wr_idx] <= 1'b1;
            end
        end
    end

    assign rd_data = val[rd_idx];
    assign rd_vld  = vld[rd_idx];

endmodule

// File: rtl/l1a_multi_checker.sv
// Walks the active channels of an event, aligns each channel's FIFO header
// with the expected L1A, passes matching data downstream and flags the rest.
module l1a_multi_checker
    import l1a_chk_pkg::*;
#(
    parameter int NCH      = 7,
    parameter int DW       = 12,
    parameter int NPOP     = 2,
    parameter int HOLD_CYC = 16,
    parameter int TMO_CYC  = 4096,
    localparam int L1AW    = l1a_width(NPOP, DW),
    localparam int SW      = sel_width(NCH),
    localparam int TW      = tmo_width(TMO_CYC)
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            HEADER_END,
    input  logic [NCH-1:0]  ACT_MASK,
    input  logic [L1AW-1:0] L1A_EXP,
    input  logic [NCH-1:0]  FIFO_MT,
    input  logic [DW-1:0]   FIFO_DATA,
    input  logic            FIFO_LAST,
    input  logic            DONE_CE,
    input  logic            CLR_CNT,
    output logic [SW-1:0]   CH_SEL,
    output logic            FIFO_RE,
    output logic            DATA_CE,
    output logic            INPROG,
    output logic            STRT_TAIL,
    output logic [NCH-1:0]  MISSING_DAT,
    output logic            NOEND_ERR,
    output logic [7:0]      ERR_CNT
);

    state_t          state;
    logic [NCH-1:0]  pend;
    logic [L1AW-1:0] exp_l1a, cap, sv_data;
    logic [TW-1:0]   tmo;
    logic            re_q, sv_vld, err_ev;
    logic [SW-1:0]   nxt;

    wire tmo_hit   = (tmo == TW'(TMO_CYC - 1));
    wire hold_done = (tmo == TW'(HOLD_CYC - 1));
    wire pop_done  = (tmo == TW'(NPOP));

    assign nxt = SW'(lowest_set(16'(pend)));

    l1a_save_bank #(.NCH(NCH), .L1AW(L1AW), .SW(SW)) u_bank (
        .CLK     (CLK),
        .RST     (RST),
        .wr_en   (state == S_CHECK && cap > exp_l1a),
        .wr_idx  (CH_SEL),
        .wr_data (cap),
        .clr_en  (state == S_SCAN && pend != '0 && sv_vld),
        .clr_idx (nxt),
        .rd_idx  (nxt),
        .rd_data (sv_data),
        .rd_vld  (sv_vld)
    );

    always_comb begin
        err_ev = 1'b0;
        case (state)
            S_WAIT:  err_ev = FIFO_MT[CH_SEL] && tmo_hit;
            S_CHECK: err_ev = cap > exp_l1a;
            S_PROC:  err_ev = !DONE_CE && tmo_hit;
            S_FLUSH: err_ev = !(re_q && FIFO_LAST) && tmo_hit;
            default: err_ev = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) ERR_CNT <= '0;
        else if (CLR_CNT) ERR_CNT <= '0;
        else if (err_ev && ERR_CNT != 8'hFF) ERR_CNT <= ERR_CNT + 8'd1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= S_IDLE;
            pend        <= '0;
            exp_l1a     <= '0;
            cap         <= '0;
            tmo         <= '0;
            re_q        <= 1'b0;
            CH_SEL      <= '0;
            FIFO_RE     <= 1'b0;
            DATA_CE     <= 1'b0;
            INPROG      <= 1'b0;
            STRT_TAIL   <= 1'b0;
            MISSING_DAT <= '0;
            NOEND_ERR   <= 1'b0;
        end else begin
            re_q      <= FIFO_RE;
            tmo       <= tmo + 1'b1;
            STRT_TAIL <= 1'b0;
            NOEND_ERR <= 1'b0;
            case (state)
                S_IDLE: if (HEADER_END) begin
                    pend        <= ACT_MASK;
                    exp_l1a     <= L1A_EXP;
                    MISSING_DAT <= '0;
                    INPROG      <= 1'b1;
                    state       <= S_HOLD;
                    tmo         <= '0;
                end
                S_HOLD: if (hold_done) begin
                    state <= S_SCAN;
                    tmo   <= '0;
                end
                S_SCAN: begin
                    tmo <= '0;
                    if (pend == '0) begin
                        state     <= S_TAIL;
                        STRT_TAIL <= 1'b1;
                        INPROG    <= 1'b0;
                    end else begin
                        CH_SEL    <= nxt;
                        pend[nxt] <= 1'b0;
                        if (sv_vld) begin
                            cap   <= sv_data;
                            state <= S_CHECK;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: if (!FIFO_MT[CH_SEL]) begin
                    state   <= S_POP;
                    FIFO_RE <= 1'b1;
                    tmo     <= '0;
                end else if (tmo_hit) begin
                    MISSING_DAT[CH_SEL] <= 1'b1;
                    state <= S_SCAN;
                    tmo   <= '0;
                end
                S_POP: begin
                    // Words return one cycle after the strobe; shift in from the top so word 0 ends lowest.
                    if (re_q) cap <= (cap >> DW) | (L1AW'(FIFO_DATA) << (L1AW - DW));
                    FIFO_RE <= (int'(tmo) + 1 < NPOP);
                    if (pop_done) begin
                        state <= S_CHECK;
                        tmo   <= '0;
                    end
                end
                S_CHECK: begin
                    tmo <= '0;
                    if (cap == exp_l1a) begin
                        state   <= S_PROC;
                        DATA_CE <= 1'b1;
                        FIFO_RE <= !FIFO_MT[CH_SEL];
                    end else if (cap < exp_l1a) begin
                        state   <= S_FLUSH;
                        FIFO_RE <= !FIFO_MT[CH_SEL];
                    end else begin
                        MISSING_DAT[CH_SEL] <= 1'b1;
                        state <= S_SCAN;
                    end
                end
                S_PROC: if (DONE_CE) begin
                    state   <= S_SCAN;
                    DATA_CE <= 1'b0;
                    FIFO_RE <= 1'b0;
                    tmo     <= '0;
                end else if (tmo_hit) begin
                    state     <= S_NOEND;
                    NOEND_ERR <= 1'b1;
                    DATA_CE   <= 1'b0;
                    FIFO_RE   <= 1'b0;
                    tmo       <= '0;
                end else begin
                    FIFO_RE <= !FIFO_MT[CH_SEL];
                end
                S_FLUSH: if (re_q && FIFO_LAST) begin
                    state   <= S_POP;
                    FIFO_RE <= 1'b1;
                    tmo     <= '0;
                end else if (tmo_hit) begin
                    MISSING_DAT[CH_SEL] <= 1'b1;
                    state   <= S_SCAN;
                    FIFO_RE <= 1'b0;
                    tmo     <= '0;
                end else begin
                    // One read in flight at a time so the word after FIFO_LAST stays in the FIFO.
                    FIFO_RE <= !FIFO_MT[CH_SEL] && !FIFO_RE;
                end
                S_NOEND: begin
                    state <= S_SCAN;
                    tmo   <= '0;
                end
                S_TAIL: begin
                    state <= S_IDLE;
                    tmo   <= '0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_l1a_multi_checker.sv
// Directed bench for l1a_multi_checker with a queue-based per-channel FIFO model.
module tb_l1a_multi_checker;

    localparam int NCH = 7, DW = 12, NPOP = 2, HOLD = 4, TMO = 64;
    localparam int L1AW = NPOP * DW;

    logic            CLK = 1'b0, RST = 1'b1;
    logic            HEADER_END = 1'b0, DONE_CE = 1'b0, CLR_CNT = 1'b0;
    logic [NCH-1:0]  ACT_MASK = '0;
    logic [L1AW-1:0] L1A_EXP = '0;
    logic [NCH-1:0]  FIFO_MT = '1;
    logic [DW-1:0]   FIFO_DATA = '0;
    logic            FIFO_LAST = 1'b0;
    logic [2:0]      CH_SEL;
    logic            FIFO_RE, DATA_CE, INPROG, STRT_TAIL, NOEND_ERR;
    logic [NCH-1:0]  MISSING_DAT;
    logic [7:0]      ERR_CNT;

    l1a_multi_checker #(.NCH(NCH), .DW(DW), .NPOP(NPOP), .HOLD_CYC(HOLD), .TMO_CYC(TMO)) dut (
        .CLK(CLK), .RST(RST), .HEADER_END(HEADER_END), .ACT_MASK(ACT_MASK), .L1A_EXP(L1A_EXP),
        .FIFO_MT(FIFO_MT), .FIFO_DATA(FIFO_DATA), .FIFO_LAST(FIFO_LAST), .DONE_CE(DONE_CE),
        .CLR_CNT(CLR_CNT), .CH_SEL(CH_SEL), .FIFO_RE(FIFO_RE), .DATA_CE(DATA_CE), .INPROG(INPROG),
        .STRT_TAIL(STRT_TAIL), .MISSING_DAT(MISSING_DAT), .NOEND_ERR(NOEND_ERR), .ERR_CNT(ERR_CNT)
    );

    always #5 CLK = ~CLK;

    logic [12:0] fq [NCH][$];
    int n_chk = 0, n_err = 0, re_total = 0, tail_total = 0;

    always @(posedge CLK) begin
        if (FIFO_RE) re_total++;
        if (STRT_TAIL) tail_total++;
        if (FIFO_RE && fq[CH_SEL].size() > 0) begin
            logic [12:0] w;
            w = fq[CH_SEL].pop_front();
            FIFO_DATA <= w[11:0];
            FIFO_LAST <= w[12];
        end else begin
            FIFO_LAST <= 1'b0;
        end
    end

    always @(negedge CLK)
        for (int i = 0; i < NCH; i++) FIFO_MT[i] <= (fq[i].size() == 0);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return 32'({CH_SEL, FIFO_RE, DATA_CE, INPROG, STRT_TAIL, MISSING_DAT, NOEND_ERR, ERR_CNT});
    endfunction

    task automatic push_hdr(input int ch, input logic [23:0] v);
        fq[ch].push_back({1'b0, v[11:0]});
        fq[ch].push_back({1'b0, v[23:12]});
    endtask

    task automatic push_dat(input int ch, input int n);
        for (int k = 0; k < n; k++) fq[ch].push_back({k == n - 1, 12'(12'hA00 + k)});
    endtask

    task automatic clear_fifos();
        for (int i = 0; i < NCH; i++) fq[i].delete();
        repeat (2) @(negedge CLK);
    endtask

    task automatic start_event(input logic [NCH-1:0] m, input logic [23:0] e);
        @(negedge CLK);
        ACT_MASK = m; L1A_EXP = e; HEADER_END = 1'b1;
        @(negedge CLK);
        HEADER_END = 1'b0;
    endtask

    // sel: 0 DATA_CE, 1 STRT_TAIL, 2 NOEND_ERR
    task automatic wait_sig(input string tag, input int sel, input int maxc);
        logic v;
        v = 1'b0;
        for (int i = 0; i < maxc && !v; i++) begin
            @(negedge CLK);
            v = (sel == 0) ? DATA_CE : (sel == 1) ? STRT_TAIL : NOEND_ERR;
        end
        chk(tag, 32'(v), 32'd1);
    endtask

    task automatic done_pulse();
        @(negedge CLK); DONE_CE = 1'b1;
        @(negedge CLK); DONE_CE = 1'b0;
    endtask

    initial begin
        int cnt, base;
        repeat (3) @(negedge CLK);
        chk("reset_outputs", outs(), 32'd0);
        RST = 1'b0;
        repeat (2) @(negedge CLK);

        // Two matching channels processed in order.
        push_hdr(0, 24'h000123); push_dat(0, 3);
        push_hdr(2, 24'h000123); push_dat(2, 3);
        start_event(7'b0000101, 24'h000123);
        chk("inprog_set", 32'(INPROG), 32'd1);
        wait_sig("t1_proc0", 0, 100);
        chk("t1_ch0", 32'(CH_SEL), 32'd0);
        repeat (8) @(negedge CLK);
        done_pulse();
        wait_sig("t1_proc2", 0, 100);
        chk("t1_ch2", 32'(CH_SEL), 32'd2);
        repeat (8) @(negedge CLK);
        done_pulse();
        wait_sig("t1_tail", 1, 20);
        chk("t1_missing", 32'(MISSING_DAT), 32'd0);
        chk("t1_inprog", 32'(INPROG), 32'd0);

        // Stale header flushed up to FIFO_LAST, then the matching header is used.
        push_hdr(1, 24'h000120); push_dat(1, 2);
        push_hdr(1, 24'h000123); push_dat(1, 2);
        start_event(7'b0000010, 24'h000123);
        wait_sig("t2_proc", 0, 200);
        chk("t2_ch1", 32'(CH_SEL), 32'd1);
        chk("t2_left", 32'(fq[1].size()), 32'd2);
        repeat (6) @(negedge CLK);
        done_pulse();
        wait_sig("t2_tail", 1, 20);
        chk("t2_errcnt", 32'(ERR_CNT), 32'd0);
        chk("t2_missing", 32'(MISSING_DAT), 32'd0);

        // Header ahead of expected: saved, then reused without reading the FIFO.
        push_hdr(3, 24'h000125); push_dat(3, 2);
        start_event(7'b0001000, 24'h000123);
        wait_sig("t3_tail", 1, 200);
        chk("t3_missing", 32'(MISSING_DAT), 32'h08);
        chk("t3_errcnt", 32'(ERR_CNT), 32'd1);
        base = re_total;
        start_event(7'b0001000, 24'h000125);
        wait_sig("t3_proc", 0, 100);
        chk("t3_no_re", 32'(re_total - base), 32'd0);
        chk("t3_ch3", 32'(CH_SEL), 32'd3);
        repeat (6) @(negedge CLK);
        done_pulse();
        wait_sig("t3_tail2", 1, 20);

        // Empty channel times out, next channel still scanned.
        push_hdr(5, 24'h000123); push_dat(5, 2);
        start_event(7'b0110000, 24'h000123);
        cnt = 0;
        while (CH_SEL != 3'd4 && cnt < 100) begin @(negedge CLK); cnt++; end
        chk("t4_sel4", 32'(CH_SEL), 32'd4);
        cnt = 0;
        while (!MISSING_DAT[4] && cnt < 200) begin @(negedge CLK); cnt++; end
        chk("t4_tmo_cycles", 32'(cnt), 32'(TMO));
        wait_sig("t4_proc5", 0, 100);
        chk("t4_ch5", 32'(CH_SEL), 32'd5);
        repeat (6) @(negedge CLK);
        done_pulse();
        wait_sig("t4_tail", 1, 20);
        chk("t4_missing", 32'(MISSING_DAT), 32'h10);
        chk("t4_errcnt", 32'(ERR_CNT), 32'd2);

        // No DONE_CE: NOEND pulse after TMO cycles in PROC.
        push_hdr(6, 24'h000123); push_dat(6, 1);
        start_event(7'b1000000, 24'h000123);
        wait_sig("t5_proc", 0, 100);
        cnt = 0;
        while (!NOEND_ERR && cnt < 200) begin @(negedge CLK); cnt++; end
        chk("t5_noend_cycles", 32'(cnt), 32'(TMO));
        chk("t5_errcnt", 32'(ERR_CNT), 32'd3);
        @(negedge CLK);
        chk("t5_noend_single", 32'(NOEND_ERR), 32'd0);
        wait_sig("t5_tail", 1, 20);

        // Drive ERR_CNT to saturation with all-empty events (7 timeouts each).
        clear_fifos();
        for (int e = 0; e < 36; e++) begin
            start_event(7'h7F, 24'h000123);
            wait_sig("sat_tail", 1, 700);
        end
        chk("sat_255", 32'(ERR_CNT), 32'd255);
        start_event(7'h7F, 24'h000123);
        wait_sig("sat_tail2", 1, 700);
        chk("sat_hold", 32'(ERR_CNT), 32'd255);
        CLR_CNT = 1'b1;
        start_event(7'b0000001, 24'h000123);
        wait_sig("clr_tail", 1, 200);
        CLR_CNT = 1'b0;
        chk("clr_priority", 32'(ERR_CNT), 32'd0);
        chk("clr_missing", 32'(MISSING_DAT), 32'd1);

        // Reset mid-PROC drops saved headers and emits no tail.
        push_hdr(0, 24'h000130); push_dat(0, 1);
        start_event(7'b0000001, 24'h000123);
        wait_sig("t6_save_tail", 1, 200);
        chk("t6_saved_err", 32'(ERR_CNT), 32'd1);
        push_hdr(1, 24'h000123); push_dat(1, 4);
        start_event(7'b0000010, 24'h000123);
        wait_sig("t6_proc", 0, 100);
        base = tail_total;
        @(negedge CLK); RST = 1'b1;
        @(negedge CLK);
        chk("t6_rst_outputs", outs(), 32'd0);
        for (int i = 0; i < NCH; i++) fq[i].delete();
        @(negedge CLK); RST = 1'b0;
        repeat (5) @(negedge CLK);
        chk("t6_no_tail", 32'(tail_total - base), 32'd0);
        push_hdr(0, 24'h000130); push_dat(0, 2);
        base = re_total;
        start_event(7'b0000001, 24'h000130);
        wait_sig("t6_proc2", 0, 100);
        chk("t6_repop", 32'(re_total - base), 32'(NPOP));
        chk("t6_ch0", 32'(CH_SEL), 32'd0);
        repeat (6) @(negedge CLK);
        done_pulse();
        wait_sig("t6_tail", 1, 20);
        chk("t6_errcnt", 32'(ERR_CNT), 32'd0);
        chk("t6_missing", 32'(MISSING_DAT), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
